// File: rtl/id_pkg.sv
// Shared decode constants, control struct and condition evaluation for the ID stage.
package id_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic [3:0] exe_cmd;
        logic       b;
        logic       s;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // sr = {N,Z,C,V}; the reserved NV encoding executes unconditionally like AL
    function automatic logic cond_pass(input cond_e c, input logic [3:0] sr);
        logic n, z, cf, v;
        {n, z, cf, v} = sr;
        case (c)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = cf;
            COND_CC: cond_pass = !cf;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = cf && !z;
            COND_LS: cond_pass = !cf || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with async reset, two combinational read ports and write-through bypass.
module reg_file_bypass #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr1,
    input  logic [3:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic wr_ok, rd1_ok, rd2_ok;

    assign wr_ok  = ({28'd0, wr_addr}  < 32'(NREGS));
    assign rd1_ok = ({28'd0, rd_addr1} < 32'(NREGS));
    assign rd2_ok = ({28'd0, rd_addr2} < 32'(NREGS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_ok) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Out-of-range addresses read 0 even when the writeback targets them
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rd1_ok) rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1[AW-1:0]];
        if (rd2_ok) rd_data2 = (wr_en && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2[AW-1:0]];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decode, condition check, operand read, RAW stall and ID/EXE register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        sr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [3:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [3:0]        mem_dest,
    output logic              stall,
    output logic              id_valid,
    output logic              id_wb_en,
    output logic              id_mem_r_en,
    output logic              id_mem_w_en,
    output logic              id_b,
    output logic              id_s,
    output logic              id_imm,
    output logic [3:0]        id_exe_cmd,
    output logic [DATA_W-1:0] id_val_rn,
    output logic [DATA_W-1:0] id_val_rm,
    output logic [11:0]       id_shift_operand,
    output logic [23:0]       id_signed_imm_24,
    output logic [3:0]        id_dest,
    output logic [3:0]        id_src1,
    output logic [3:0]        id_src2,
    output logic [DATA_W-1:0] id_pc
);
    logic [1:0]        mode;
    logic [3:0]        opcode, src1, src2, dest;
    logic              s_bit, imm;
    ctrl_t             ctrl, ctrl_q;
    logic              decode_ok, uses_rn, uses_rm, cond_ok, hazard, load;
    logic [DATA_W-1:0] val_rn, val_rm;

    assign mode   = instruction[27:26];
    assign imm    = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign src1   = instruction[19:16];
    assign dest   = instruction[15:12];
    assign src2   = ctrl.mem_w_en ? instruction[15:12] : instruction[3:0];

    always_comb begin
        ctrl      = CTRL_BUBBLE;
        decode_ok = 1'b0;
        uses_rn   = 1'b0;
        uses_rm   = 1'b0;
        case (mode)
            MODE_ALU: begin
                decode_ok    = 1'b1;
                ctrl.wb_en   = 1'b1;
                ctrl.s       = s_bit;
                uses_rn      = 1'b1;
                uses_rm      = !imm;
                case (opcode)
                    OP_MOV: begin ctrl.exe_cmd = CMD_MOV; uses_rn = 1'b0; end
                    OP_MVN: begin ctrl.exe_cmd = CMD_MVN; uses_rn = 1'b0; end
                    OP_ADD: ctrl.exe_cmd = CMD_ADD;
                    OP_ADC: ctrl.exe_cmd = CMD_ADC;
                    OP_SUB: ctrl.exe_cmd = CMD_SUB;
                    OP_SBC: ctrl.exe_cmd = CMD_SBC;
                    OP_AND: ctrl.exe_cmd = CMD_AND;
                    OP_ORR: ctrl.exe_cmd = CMD_ORR;
                    OP_EOR: ctrl.exe_cmd = CMD_EOR;
                    OP_CMP: begin ctrl.exe_cmd = CMD_SUB; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
                    OP_TST: begin ctrl.exe_cmd = CMD_AND; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
                    default: begin ctrl = CTRL_BUBBLE; decode_ok = 1'b0; end
                endcase
            end
            MODE_MEM: begin
                decode_ok     = 1'b1;
                ctrl.exe_cmd  = CMD_ADD;
                ctrl.mem_r_en = s_bit;
                ctrl.wb_en    = s_bit;
                ctrl.mem_w_en = !s_bit;
                uses_rn       = 1'b1;
                uses_rm       = !s_bit || !imm;
            end
            MODE_BR: begin
                decode_ok = 1'b1;
                ctrl.b    = 1'b1;
            end
            default: ;
        endcase
    end

    assign cond_ok = cond_pass(cond_e'(instruction[31:28]), sr);

    // With forwarding downstream only a load in EXE cannot be forwarded in time
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = instr_valid && exe_mem_r_en && exe_wb_en &&
                     ((uses_rn && src1 == exe_dest) || (uses_rm && src2 == exe_dest));
        end else begin
            hazard = instr_valid &&
                     ((exe_wb_en && ((uses_rn && src1 == exe_dest) || (uses_rm && src2 == exe_dest))) ||
                      (mem_wb_en && ((uses_rn && src1 == mem_dest) || (uses_rm && src2 == mem_dest))));
        end
    end

    assign stall = hazard && !flush && !rst;
    assign load  = instr_valid && cond_ok && decode_ok && !flush && !stall;

    reg_file_bypass #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_addr  (wb_dest),
        .wr_data  (wb_value),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (val_rn),
        .rd_data2 (val_rm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid         <= 1'b0;
            ctrl_q           <= CTRL_BUBBLE;
            id_imm           <= 1'b0;
            id_val_rn        <= '0;
            id_val_rm        <= '0;
            id_shift_operand <= '0;
            id_signed_imm_24 <= '0;
            id_dest          <= '0;
            id_src1          <= '0;
            id_src2          <= '0;
            id_pc            <= '0;
        end else begin
            id_valid         <= load;
            ctrl_q           <= load ? ctrl : CTRL_BUBBLE;
            id_imm           <= load && imm;
            id_val_rn        <= val_rn;
            id_val_rm        <= val_rm;
            id_shift_operand <= instruction[11:0];
            id_signed_imm_24 <= instruction[23:0];
            id_dest          <= dest;
            id_src1          <= src1;
            id_src2          <= src2;
            id_pc            <= pc_in;
        end
    end

    assign id_wb_en    = ctrl_q.wb_en;
    assign id_mem_r_en = ctrl_q.mem_r_en;
    assign id_mem_w_en = ctrl_q.mem_w_en;
    assign id_exe_cmd  = ctrl_q.exe_cmd;
    assign id_b        = ctrl_q.b;
    assign id_s        = ctrl_q.s;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench driving one FWD_EN=0 and one FWD_EN=1 instance from shared inputs.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic [3:0]  sr;
    logic        flush, wb_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic [3:0]  wb_dest, exe_dest, mem_dest;
    logic [31:0] wb_value;

    logic        a_stall, a_valid, a_wb_en, a_mem_r_en, a_mem_w_en, a_b, a_s, a_imm;
    logic [3:0]  a_exe_cmd, a_dest, a_src1, a_src2;
    logic [31:0] a_val_rn, a_val_rm, a_pc;
    logic [11:0] a_shift;
    logic [23:0] a_simm;

    logic        b_stall, b_valid, b_wb_en, b_mem_r_en, b_mem_w_en, b_b, b_s, b_imm;
    logic [3:0]  b_exe_cmd, b_dest, b_src1, b_src2;
    logic [31:0] b_val_rn, b_val_rm, b_pc;
    logic [11:0] b_shift;
    logic [23:0] b_simm;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .NREGS(16), .FWD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .pc_in(pc_in), .sr(sr), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall(a_stall), .id_valid(a_valid), .id_wb_en(a_wb_en), .id_mem_r_en(a_mem_r_en),
        .id_mem_w_en(a_mem_w_en), .id_b(a_b), .id_s(a_s), .id_imm(a_imm),
        .id_exe_cmd(a_exe_cmd), .id_val_rn(a_val_rn), .id_val_rm(a_val_rm),
        .id_shift_operand(a_shift), .id_signed_imm_24(a_simm), .id_dest(a_dest),
        .id_src1(a_src1), .id_src2(a_src2), .id_pc(a_pc)
    );

    id_stage_pipe #(.DATA_W(32), .NREGS(16), .FWD_EN(1)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .pc_in(pc_in), .sr(sr), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall(b_stall), .id_valid(b_valid), .id_wb_en(b_wb_en), .id_mem_r_en(b_mem_r_en),
        .id_mem_w_en(b_mem_w_en), .id_b(b_b), .id_s(b_s), .id_imm(b_imm),
        .id_exe_cmd(b_exe_cmd), .id_val_rn(b_val_rn), .id_val_rm(b_val_rm),
        .id_shift_operand(b_shift), .id_signed_imm_24(b_simm), .id_dest(b_dest),
        .id_src1(b_src1), .id_src2(b_src2), .id_pc(b_pc)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        flush        = 1'b0;
        wb_en        = 1'b0;
        wb_dest      = 4'd0;
        wb_value     = 32'd0;
        exe_wb_en    = 1'b0;
        exe_mem_r_en = 1'b0;
        exe_dest     = 4'd0;
        mem_wb_en    = 1'b0;
        mem_dest     = 4'd0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = ins;
        pc_in       = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'd0;
        pc_in = 32'd0;
        sr = 4'b0000;
        clear_side();
        #2;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_exe_cmd", 32'(b_exe_cmd), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload R2=5, R3=7
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd5;
        @(negedge clk);
        wb_dest = 4'd3; wb_value = 32'd7;
        @(negedge clk);
        clear_side();

        // ADD R1,R2,R3
        issue(32'hE0821003, 32'h100);
        chk("add_stall0", 32'(a_stall), 32'd0);
        tick();
        chk("add_valid", 32'(a_valid), 32'd1);
        chk("add_cmd", 32'(a_exe_cmd), 32'h2);
        chk("add_wb", 32'(a_wb_en), 32'd1);
        chk("add_rn", a_val_rn, 32'd5);
        chk("add_rm", a_val_rm, 32'd7);
        chk("add_dest", 32'(a_dest), 32'd1);
        chk("add_src2", 32'(a_src2), 32'd3);
        chk("add_pc", a_pc, 32'h100);
        chk("add_shift", 32'(a_shift), 32'h003);
        chk("add_simm", 32'(a_simm), 32'h821003);

        // Same-cycle writeback of R2 bypasses the array
        issue(32'hE0821003, 32'h104);
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd9;
        tick();
        chk("bypass_rn", a_val_rn, 32'd9);
        chk("bypass_rm", a_val_rm, 32'd7);
        clear_side();

        // RAW against EXE (non-load)
        issue(32'hE0821003, 32'h108);
        exe_wb_en = 1'b1; exe_dest = 4'd3;
        #1;
        chk("raw_exe_stall_f0", 32'(a_stall), 32'd1);
        chk("raw_exe_stall_f1", 32'(b_stall), 32'd0);
        tick();
        chk("raw_exe_bubble_f0", 32'(a_valid), 32'd0);
        chk("raw_exe_wb_f0", 32'(a_wb_en), 32'd0);
        chk("raw_exe_valid_f1", 32'(b_valid), 32'd1);
        clear_side();

        // Load-use on Rn
        issue(32'hE0821003, 32'h10C);
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd2;
        #1;
        chk("ld_use_stall_f0", 32'(a_stall), 32'd1);
        chk("ld_use_stall_f1", 32'(b_stall), 32'd1);
        tick();
        chk("ld_use_bubble_f1", 32'(b_valid), 32'd0);

        // Same hazard with flush: flush wins
        flush = 1'b1;
        #1;
        chk("flush_stall_f0", 32'(a_stall), 32'd0);
        chk("flush_stall_f1", 32'(b_stall), 32'd0);
        tick();
        chk("flush_valid_f0", 32'(a_valid), 32'd0);
        chk("flush_wb_f1", 32'(b_wb_en), 32'd0);
        chk("flush_valid_f1", 32'(b_valid), 32'd0);
        clear_side();

        // RAW against MEM
        issue(32'hE0821003, 32'h110);
        mem_wb_en = 1'b1; mem_dest = 4'd2;
        #1;
        chk("raw_mem_stall_f0", 32'(a_stall), 32'd1);
        chk("raw_mem_stall_f1", 32'(b_stall), 32'd0);
        clear_side();

        // MOVEQ R4,#5 with Z=0 then Z=1
        issue(32'h03A04005, 32'h114);
        sr = 4'b0000;
        tick();
        chk("moveq_nz_valid", 32'(b_valid), 32'd0);
        chk("moveq_nz_wb", 32'(b_wb_en), 32'd0);
        issue(32'h03A04005, 32'h118);
        sr = 4'b0100;
        exe_wb_en = 1'b1; exe_dest = 4'd0;
        #1;
        chk("mov_no_src_stall", 32'(a_stall), 32'd0);
        tick();
        chk("moveq_z_valid", 32'(a_valid), 32'd1);
        chk("moveq_z_cmd", 32'(a_exe_cmd), 32'h1);
        chk("moveq_z_wb", 32'(a_wb_en), 32'd1);
        chk("moveq_z_imm", 32'(a_imm), 32'd1);
        chk("moveq_z_dest", 32'(a_dest), 32'd4);
        clear_side();
        sr = 4'b0000;

        // CMP R2,R3
        issue(32'hE1520003, 32'h11C);
        tick();
        chk("cmp_cmd", 32'(a_exe_cmd), 32'h4);
        chk("cmp_wb", 32'(a_wb_en), 32'd0);
        chk("cmp_s", 32'(a_s), 32'd1);
        chk("cmp_rn", a_val_rn, 32'd9);

        // LDR R5,[R2,#4] with EXE writing R5: no source conflict
        issue(32'hE5925004, 32'h120);
        exe_wb_en = 1'b1; exe_dest = 4'd5;
        #1;
        chk("ldr_stall_f0", 32'(a_stall), 32'd0);
        tick();
        chk("ldr_mem_r", 32'(a_mem_r_en), 32'd1);
        chk("ldr_wb", 32'(a_wb_en), 32'd1);
        chk("ldr_cmd", 32'(a_exe_cmd), 32'h2);
        chk("ldr_s", 32'(a_s), 32'd0);

        // STR R5,[R2,#4]: Rd is a source
        issue(32'hE5825004, 32'h124);
        #1;
        chk("str_stall_f0", 32'(a_stall), 32'd1);
        chk("str_stall_f1", 32'(b_stall), 32'd0);
        tick();
        chk("str_mem_w_f1", 32'(b_mem_w_en), 32'd1);
        chk("str_wb_f1", 32'(b_wb_en), 32'd0);
        chk("str_src2_f1", 32'(b_src2), 32'd5);
        chk("str_rm_f1", b_val_rm, 32'd0);
        clear_side();

        // Branch: no register sources
        issue(32'hEA000010, 32'h128);
        exe_wb_en = 1'b1; exe_dest = 4'd0;
        #1;
        chk("br_stall_f0", 32'(a_stall), 32'd0);
        tick();
        chk("br_b", 32'(a_b), 32'd1);
        chk("br_valid", 32'(a_valid), 32'd1);
        chk("br_wb", 32'(a_wb_en), 32'd0);
        chk("br_simm", 32'(a_simm), 32'h000010);
        clear_side();

        // Undefined ALU opcode 0011
        issue(32'hE0621003, 32'h12C);
        tick();
        chk("undef_valid", 32'(a_valid), 32'd0);
        chk("undef_wb", 32'(a_wb_en), 32'd0);

        // Invalid instruction never stalls
        issue(32'hE0821003, 32'h130);
        instr_valid = 1'b0;
        exe_wb_en = 1'b1; exe_dest = 4'd3;
        #1;
        chk("inv_stall_f0", 32'(a_stall), 32'd0);
        tick();
        chk("inv_valid_f0", 32'(a_valid), 32'd0);

        // Async reset in the middle of a stall
        issue(32'hE0821003, 32'h134);
        tick();
        chk("pre_rst_valid_f1", 32'(b_valid), 32'd1);
        chk("pre_rst_stall_f0", 32'(a_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(a_stall), 32'd0);
        chk("mid_rst_valid_f1", 32'(b_valid), 32'd0);
        chk("mid_rst_rn_f1", b_val_rn, 32'd0);
        chk("mid_rst_pc_f1", b_pc, 32'd0);
        chk("mid_rst_cmd_f1", 32'(b_exe_cmd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_side();
        issue(32'hE0821003, 32'h200);
        tick();
        chk("post_rst_valid", 32'(a_valid), 32'd1);
        chk("post_rst_rn", a_val_rn, 32'd0);
        chk("post_rst_rm", a_val_rm, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised next-generation instruction-decode stage: decode, condition check, register-file read with write-through bypass, RAW hazard detection with optional forwarding mode, and an ID/EXE pipeline register. Sits between the IF/ID register and the EXE stage; drives stall to IF and registered decoded fields to EXE. Adds internal hazard detection, bypass, flush/stall priority and registered outputs.

Parameters:
DATA_W, 32, register and operand width
NREGS, 16, architectural register count (power of 2, at most 16)
FWD_EN, 1, 1 = forwarding present downstream: stall only on load-use; 0 = stall on any RAW against EXE or MEM

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction from IF/ID is valid
instruction  in  32  instruction word
pc_in  in  DATA_W  PC of instruction
sr  in  4  status {N,Z,C,V}
flush  in  1  branch taken, kill instruction in ID
wb_en  in  1  writeback enable
wb_dest  in  4  writeback register
wb_value  in  DATA_W  writeback data
exe_wb_en, exe_mem_r_en  in  1 each  EXE-stage control
exe_dest  in  4  EXE-stage destination
mem_wb_en  in  1  MEM-stage writeback enable
mem_dest  in  4  MEM-stage destination
stall  out  1  combinational; IF and IF/ID hold
id_valid  out  1  registered; EXE holds a real instruction
id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  out  1 each  registered control
id_exe_cmd  out  4  registered ALU command
id_val_rn, id_val_rm  out  DATA_W  registered operands
id_shift_operand  out  12  instruction[11:0]
id_signed_imm_24  out  24  instruction[23:0]
id_dest, id_src1, id_src2  out  4 each  registered register indices
id_pc  out  DATA_W  registered PC

Behaviour:
- Reset: all id_* outputs and all registers of the register file = 0; stall = 0 while rst high.
- Decode: mode = instr[27:26], opcode = instr[24:21], s = instr[20], imm = instr[25].
- Mode 00: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000 (all wb_en=1); CMP 1010->0100, TST 1000->0110 (wb_en=0, s forced 1). Undefined opcodes are treated as a bubble.
- Mode 01: exe_cmd 0010; s=1 gives LDR (mem_r_en=1, wb_en=1); s=0 gives STR (mem_w_en=1); id_s = 0.
- Mode 10: b=1, all other control bits 0.
- src1 = instr[19:16]; src2 = instr[15:12] when STR, else instr[3:0]; dest = instr[15:12].
- Source use: uses_rn = not (MOV, MVN, branch); uses_rm = two_src = mem_w_en or not imm (branch: 0).
- Condition: ARM cond codes EQ..AL over sr. A fail gives a bubble.
- Hazard, FWD_EN=0: instr_valid and (exe_wb_en and used src == exe_dest, or mem_wb_en and used src == mem_dest).
- Hazard, FWD_EN=1: instr_valid and exe_mem_r_en and exe_wb_en and used src == exe_dest.
- stall = hazard and not flush.
- Register file: write on rising clk when wb_en. Read is combinational with bypass: if wb_en and wb_dest == read address, return wb_value. Addresses at or above NREGS read 0 and ignore writes.
- ID/EXE register, 1-cycle latency. Per-edge priority: flush > stall > condition fail / invalid > decode.
  - Bubble: id_valid = 0 and all control bits = 0; data fields are don't-care, loaded with the decode values.
  - Otherwise: load decoded fields and set id_valid = 1.
- Stall inserts a bubble downstream; the ID instruction is re-evaluated next cycle.
- Reset mid-stall clears the pipe register and drops stall immediately.

Decomposition:
- Package id_pkg holds:
  - exe_cmd localparams
  - mode and opcode codes
  - cond-code enum
  - the decoded-control struct {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}
  - the bubble constant
- One sub-module, reg_file_bypass (parameters DATA_W, NREGS).
- Decode, condition and hazard logic stay as combinational always blocks in id_stage_pipe.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), R2=5, R3=7, no hazards -> next cycle id_valid=1, id_exe_cmd=0010, id_wb_en=1, id_val_rn=5, id_val_rm=7, id_dest=1.
- Same-cycle wb_en=1, wb_dest=2, wb_value=9 with ADD R1,R2,R3 -> id_val_rn=9 (bypass).
- FWD_EN=0: exe_wb_en=1, exe_dest=3, instruction uses R3 -> stall=1, next id_valid=0. With FWD_EN=1 and exe_mem_r_en=0 -> stall=0.
- MOVEQ with sr Z=0 -> bubble (id_valid=0, id_wb_en=0). With Z=1 -> id_exe_cmd=0001.
- Hazard condition plus flush=1 in the same cycle -> stall=0, bubble loaded.
- Assert rst asynchronously mid-stall -> all id_* = 0 before the next edge; the register file reads 0.
